// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: queues EX-stage branch-resolution updates and feeds them,
// one per cycle, into the BTB's single write port. An update whose set index
// matches the current fetch index is held back, but never for more than
// MAX_HOLD cycles. A flush request discards queued updates and sweeps a clear
// strobe across every BTB set.
module btb_update_ctrl #(
  parameter int DEPTH    = 4,
  parameter int NUM_SETS = 8,
  parameter int INDEX_W  = 3,
  parameter int MAX_HOLD = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_pc,
  input  logic [31:0]                req_target,
  input  logic                       req_mispredicted,
  input  logic [31:0]                fetch_pc,
  input  logic                       flush_req,
  output logic                       flush_busy,
  output logic                       btb_update,
  output logic [31:0]                btb_update_pc,
  output logic [31:0]                btb_update_target,
  output logic                       btb_mispredicted,
  output logic                       btb_clear,
  output logic [INDEX_W-1:0]         btb_clear_index,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [INDEX_W-1:0]   sweep_q, sweep_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Payload storage carries no reset; every read of it is gated by occupancy.
  logic [31:0]          pc_mem_q  [DEPTH];
  logic [31:0]          tgt_mem_q [DEPTH];
  logic                 mis_mem_q [DEPTH];

  logic                 empty;
  logic                 full;
  logic                 conflict;
  logic                 push;
  logic                 pop;
  logic [31:0]          head_pc;

  // Only the set-index bits of the fetch PC take part in the conflict check.
  logic                 fetch_pc_unused;
  assign fetch_pc_unused = ^{fetch_pc[31:INDEX_W+2], fetch_pc[1:0]};

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign head_pc  = pc_mem_q[rd_ptr_q];
  assign conflict = !empty && (head_pc[INDEX_W+1:2] == fetch_pc[INDEX_W+1:2]);
  assign count    = count_q;

  // Control state: FSM, sweep index, starvation counter and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      sweep_q  <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Capture an accepted request into the tail slot of the FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]  <= req_pc;
      tgt_mem_q[wr_ptr_q] <= req_target;
      mis_mem_q[wr_ptr_q] <= req_mispredicted;
    end
  end

  // Next-state and outputs: issue/deferral in RUN, clear sweep in FLUSH.
  always_comb begin
    state_d           = state_q;
    sweep_d           = sweep_q;
    hold_d            = hold_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    count_d           = count_q;
    req_ready         = 1'b0;
    btb_update        = 1'b0;
    btb_update_pc     = '0;
    btb_update_target = '0;
    btb_mispredicted  = 1'b0;
    btb_clear         = 1'b0;
    btb_clear_index   = '0;
    flush_busy        = 1'b0;
    push              = 1'b0;
    pop               = 1'b0;

    case (state_q)
      RUN: begin
        req_ready  = !full && !flush_req;
        // A conflicting head waits unless it has already waited MAX_HOLD cycles.
        btb_update = !empty && !flush_req &&
                     (!conflict || (hold_q == HOLD_W'(MAX_HOLD)));
        if (!empty) begin
          btb_update_pc     = head_pc;
          btb_update_target = tgt_mem_q[rd_ptr_q];
          btb_mispredicted  = mis_mem_q[rd_ptr_q];
        end
        push = req_valid && req_ready;
        pop  = btb_update;

        if (flush_req) begin
          state_d  = FLUSH;
          sweep_d  = '0;
          hold_d   = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d = count_q + CNT_W'(push) - CNT_W'(pop);
          if (pop) begin
            hold_d = '0;
          end else if (conflict && (hold_q != HOLD_W'(MAX_HOLD))) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      FLUSH: begin
        btb_clear       = 1'b1;
        btb_clear_index = sweep_q;
        flush_busy      = 1'b1;
        // Further flush requests are ignored; the sweep always ends after the last set.
        if (sweep_q == INDEX_W'(NUM_SETS - 1)) begin
          state_d = RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + INDEX_W'(1);
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Testbench for btb_update_ctrl: directed scenarios followed by random traffic,
// checked against a queue-based reference model through a scoreboard.
module tb_btb_update_ctrl;

  localparam int DEPTH    = 4;
  localparam int NUM_SETS = 8;
  localparam int INDEX_W  = 3;
  localparam int MAX_HOLD = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_pc;
  logic [31:0]        req_target;
  logic               req_mispredicted;
  logic [31:0]        fetch_pc;
  logic               flush_req;
  logic               flush_busy;
  logic               btb_update;
  logic [31:0]        btb_update_pc;
  logic [31:0]        btb_update_target;
  logic               btb_mispredicted;
  logic               btb_clear;
  logic [INDEX_W-1:0] btb_clear_index;
  logic [2:0]         count;

  btb_update_ctrl #(
    .DEPTH(DEPTH), .NUM_SETS(NUM_SETS), .INDEX_W(INDEX_W), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_target(req_target), .req_mispredicted(req_mispredicted),
    .fetch_pc(fetch_pc), .flush_req(flush_req), .flush_busy(flush_busy),
    .btb_update(btb_update), .btb_update_pc(btb_update_pc),
    .btb_update_target(btb_update_target), .btb_mispredicted(btb_mispredicted),
    .btb_clear(btb_clear), .btb_clear_index(btb_clear_index), .count(count)
  );

  always #5 clk = ~clk;

  // Scoreboard records
  typedef struct {
    bit          is_clear;
    logic [31:0] pc;
    logic [31:0] tgt;
    bit          mis;
    int          cidx;
  } ev_t;

  typedef struct {
    bit          ready;
    bit          upd;
    bit          clr;
    bit          busy;
    int          cnt;
    logic [31:0] ppc;
  } stat_t;

  ev_t   ev_q[$];
  stat_t stat_q[$];

  // Reference model state
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    bit          mis;
  } ent_t;

  ent_t m_fifo[$];
  int   m_hold;
  bit   m_flush;
  int   m_sweep;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int set_idx(input logic [31:0] a);
    return int'((a >> 2) % (1 << INDEX_W));
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    m_hold  = 0;
    m_flush = 0;
    m_sweep = 0;
  endfunction

  // One clock cycle: drive inputs, predict outputs, then advance the model at the edge.
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                      input bit mis, input logic [31:0] fpc, input bit fl);
    stat_t s;
    ev_t   e;
    bit    conf;
    bit    upd;
    bit    rdy;
    req_valid        = v;
    req_pc           = pc;
    req_target       = tgt;
    req_mispredicted = mis;
    fetch_pc         = fpc;
    flush_req        = fl;

    rdy  = !m_flush && (m_fifo.size() < DEPTH) && !fl;
    conf = !m_flush && (m_fifo.size() > 0) && (set_idx(m_fifo[0].pc) == set_idx(fpc));
    upd  = !m_flush && (m_fifo.size() > 0) && !fl && (!conf || m_hold == MAX_HOLD);

    s.ready = rdy;
    s.upd   = upd;
    s.clr   = m_flush;
    s.busy  = m_flush;
    s.cnt   = m_fifo.size();
    s.ppc   = (!m_flush && m_fifo.size() > 0) ? m_fifo[0].pc : 32'h0;
    stat_q.push_back(s);

    if (upd) begin
      e.is_clear = 0; e.pc = m_fifo[0].pc; e.tgt = m_fifo[0].tgt; e.mis = m_fifo[0].mis; e.cidx = 0;
      ev_q.push_back(e);
    end
    if (m_flush) begin
      e.is_clear = 1; e.pc = 0; e.tgt = 0; e.mis = 0; e.cidx = m_sweep;
      ev_q.push_back(e);
    end

    @(posedge clk);

    if (m_flush) begin
      m_sweep++;
      if (m_sweep == NUM_SETS) begin
        m_flush = 0;
        m_sweep = 0;
      end
    end else if (fl) begin
      m_fifo.delete();
      m_hold  = 0;
      m_flush = 1;
      m_sweep = 0;
    end else begin
      if (upd) begin
        void'(m_fifo.pop_front());
        m_hold = 0;
      end else if (conf && m_hold < MAX_HOLD) begin
        m_hold++;
      end
      if (v && rdy) begin
        ent_t n;
        n.pc = pc; n.tgt = tgt; n.mis = mis;
        m_fifo.push_back(n);
      end
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] fpc, input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 32'h0, 0, fpc, 0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must drop without a clock edge.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    check("rst_async_clear", btb_clear, 0);
    check("rst_async_busy", flush_busy, 0);
    check("rst_async_update", btb_update, 0);
    check("rst_async_count", count, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares status every checked cycle and pops a transaction on each strobe.
  always @(negedge clk) begin
    if (!rst && stat_q.size() > 0) begin
      stat_t s;
      s = stat_q.pop_front();
      check("req_ready", req_ready, s.ready);
      check("btb_update", btb_update, s.upd);
      check("btb_clear", btb_clear, s.clr);
      check("flush_busy", flush_busy, s.busy);
      check("count", count, s.cnt);
      check("payload_pc", btb_update_pc, s.ppc);
      if (btb_update || btb_clear) begin
        if (ev_q.size() == 0) begin
          check("unexpected_strobe", {btb_update, btb_clear}, 0);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          if (e.is_clear) begin
            check("clear_index", btb_clear_index, e.cidx);
          end else begin
            check("upd_pc", btb_update_pc, e.pc);
            check("upd_target", btb_update_target, e.tgt);
            check("upd_mis", btb_mispredicted, e.mis);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 0; req_pc = 0; req_target = 0; req_mispredicted = 0;
    fetch_pc = 0; flush_req = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_count", count, 0);
    check("reset_update", btb_update, 0);
    check("reset_clear", btb_clear, 0);
    check("reset_clear_index", btb_clear_index, 0);
    check("reset_busy", flush_busy, 0);
    rst = 1'b0;

    // Idle after reset
    idle(32'h204, 2);

    // Basic issue: idx 0 entry, fetch at idx 1
    step(1, 32'h100, 32'hAAA0, 1, 32'h204, 0);
    idle(32'h204, 2);

    // Starvation: held for MAX_HOLD cycles then forced
    step(1, 32'h108, 32'hBBB0, 0, 32'h308, 0);
    idle(32'h308, 5);
    // Conflict released early by a fetch index change
    step(1, 32'h108, 32'hBBB4, 1, 32'h308, 0);
    idle(32'h308, 1);
    idle(32'h314, 2);

    // Backpressure: keep requesting under conflict until full, with push+pop overlap
    for (int i = 0; i < 10; i++)
      step(1, 32'h108 + 32'(i) * 32'h20, 32'hC000 + 32'(i), i[0], 32'h308, 0);
    idle(32'h314, 6);

    // Flush with entries queued and a second flush request mid-sweep
    step(1, 32'h108, 32'hD000, 0, 32'h308, 0);
    step(1, 32'h128, 32'hD004, 1, 32'h308, 0);
    step(0, 32'h0, 32'h0, 0, 32'h308, 1);
    idle(32'h308, 3);
    step(0, 32'h0, 32'h0, 0, 32'h308, 1);
    idle(32'h308, 6);

    // Reset in the middle of a sweep
    step(1, 32'h140, 32'hE000, 0, 32'h308, 0);
    step(0, 32'h0, 32'h0, 0, 32'h308, 1);
    idle(32'h308, 4);
    async_reset();
    idle(32'h204, 2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      logic [31:0] fpc;
      pc  = ($urandom & 32'hFFFF_FFE0) | (32'($urandom_range(0, 1)) << 2);
      fpc = ($urandom & 32'hFFFF_FFE0) | (32'($urandom_range(0, 2)) << 2);
      step($urandom_range(0, 99) < 60, pc, $urandom, 1'($urandom), fpc,
           $urandom_range(0, 79) == 0);
    end
    idle(32'h0, 12);

    @(negedge clk);
    #1;
    check("scoreboard_drained", ev_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
